fb_scanout: RTL and testbench

- Read-side master for the rasterizer framebuffer memory: walks the buffer in raster order through its asynchronous read port.
- Emits one pixel per cycle on a valid/ready stream with frame and line markers.
- Sits between the framebuffer and the display/readback path; a frame is triggered by a start pulse once rasterization of that frame is complete.

---
 rtl/fb_pkg.sv | 27 ++
 rtl/fb_scanout_if.sv | 31 +++
 rtl/fb_scanout_raster_counter.sv | 52 +++++
 rtl/fb_scanout.sv | 119 +++++++++++
 tb/tb_fb_scanout.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry defaults and scan-out types for the raster pipeline.
package fb_pkg;

    localparam int FB_WIDTH     = 16;
    localparam int FB_HEIGHT    = 16;
    localparam int FB_ADDR_SIZE = 8;
    localparam int FB_DATA_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } scan_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_marks_t;

    // Default-size pixel beat; blocks with a non-default DATA_SIZE carry data separately.
    typedef struct packed {
        logic [FB_DATA_SIZE-1:0] data;
        pix_marks_t              marks;
    } pix_beat_t;

endpackage

// File: rtl/fb_scanout_if.sv
// Pixel stream from the framebuffer scan-out to the display/readback path.
interface fb_scanout_if #(
    parameter int DATA_SIZE = fb_pkg::FB_DATA_SIZE
);

    logic [DATA_SIZE-1:0] pix_data;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_sof;
    logic                 pix_eol;
    logic                 pix_eof;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_sof,
        output pix_eol,
        output pix_eof,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_sof,
        input  pix_eol,
        input  pix_eof,
        output pix_ready
    );

endinterface

// File: rtl/fb_scanout_raster_counter.sv
// Raster-order x/y walker with a linear address; shared by the framebuffer read and write sides.
module raster_counter
    import fb_pkg::*;
#(
    parameter int WIDTH     = FB_WIDTH,
    parameter int HEIGHT    = FB_HEIGHT,
    parameter int ADDR_SIZE = FB_ADDR_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     advance,
    output logic [$clog2(WIDTH):0]   x,
    output logic [$clog2(HEIGHT):0]  y,
    output logic [ADDR_SIZE-1:0]     addr,
    output logic                     first,
    output logic                     line_end,
    output logic                     frame_end
);

    localparam int XW = $clog2(WIDTH) + 1;
    localparam int YW = $clog2(HEIGHT) + 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    assign first     = (x == '0) && (y == '0);
    assign line_end  = (x == X_LAST);
    assign frame_end = line_end && (y == Y_LAST);

    // Advancing past the last pixel wraps everything to 0 so addr stays inside the frame.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            if (frame_end) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end else if (line_end) begin
                x    <= '0;
                y    <= y + 1'b1;
                addr <= addr + 1'b1;
            end else begin
                x    <= x + 1'b1;
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: reads the buffer in raster order and streams one pixel per cycle.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int ADDR_SIZE = FB_ADDR_SIZE,
    parameter int DATA_SIZE = FB_DATA_SIZE,
    parameter int WIDTH     = FB_WIDTH,
    parameter int HEIGHT    = FB_HEIGHT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] read_addr,
    input  logic [DATA_SIZE-1:0] read_data,
    fb_scanout_if.master         pix
);

    scan_state_t state;
    scan_state_t state_nxt;

    logic [$clog2(WIDTH):0]  scan_x;
    logic [$clog2(HEIGHT):0] scan_y;
    logic                    first;
    logic                    line_end;
    logic                    frame_end;

    logic       clear;
    logic       load;
    logic       finish;
    pix_marks_t marks_q;

    raster_counter #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .advance   (load),
        .x         (scan_x),
        .y         (scan_y),
        .addr      (read_addr),
        .first     (first),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        load      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                    clear     = 1'b1;
                end
            end
            SCAN: begin
                load = !pix.pix_valid || pix.pix_ready;
                if (load && frame_end) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pix.pix_valid && pix.pix_ready) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            pix.pix_valid <= 1'b0;
            pix.pix_data  <= '0;
            marks_q       <= '0;
        end else begin
            done <= finish;
            if (clear) begin
                busy <= 1'b1;
            end
            if (load) begin
                pix.pix_valid <= 1'b1;
                pix.pix_data  <= read_data;
                marks_q       <= '{sof: first, eol: line_end, eof: frame_end};
            end
            if (finish) begin
                pix.pix_valid <= 1'b0;
                busy          <= 1'b0;
            end
        end
    end

    assign pix.pix_sof = marks_q.sof;
    assign pix.pix_eol = marks_q.eol;
    assign pix.pix_eof = marks_q.eof;

    // The linear address must always agree with the x/y position it stands for.
    addr_matches_xy: assert property (@(posedge clk) disable iff (rst)
        (state == SCAN) |-> (read_addr == ADDR_SIZE'(int'(scan_y) * WIDTH + int'(scan_x))));

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: 4x2 frame against a queue model, plus a 1x1 instance.
module tb_fb_scanout;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data;
    logic [DW-1:0] mem [N];

    logic          start1;
    logic          busy1;
    logic          done1;
    logic [AW-1:0] read_addr1;
    logic [DW-1:0] read_data1;

    fb_scanout_if #(.DATA_SIZE(DW)) pix ();
    fb_scanout_if #(.DATA_SIZE(DW)) pix1 ();

    fb_scanout #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .WIDTH     (W),
        .HEIGHT    (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .read_addr (read_addr),
        .read_data (read_data),
        .pix       (pix)
    );

    fb_scanout #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .WIDTH     (1),
        .HEIGHT    (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .busy      (busy1),
        .done      (done1),
        .read_addr (read_addr1),
        .read_data (read_data1),
        .pix       (pix1)
    );

    assign read_data  = mem[read_addr[$clog2(N)-1:0]];
    assign read_data1 = (read_addr1 == '0) ? 8'hA5 : 8'h00;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ready_mode: 0 always 1, 1 repeating 1,0,0, 2 random, 3 held 0
    int ready_mode = 0;
    int phase      = 0;
    initial begin
        pix.pix_ready  = 1'b0;
        pix1.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            phase++;
            case (ready_mode)
                0:       pix.pix_ready = 1'b1;
                1:       pix.pix_ready = (phase % 3 == 0);
                2:       pix.pix_ready = 1'($urandom_range(0, 1));
                default: pix.pix_ready = 1'b0;
            endcase
        end
    end

    // Reference model: a frame is the buffer contents in address order with positional markers.
    beat_t exp_q[$];

    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back('{data: mem[i], sof: (i == 0), eol: (i % W == W - 1), eof: (i == N - 1)});
        end
    endtask

    logic s_edge     = 1'b0;
    logic r_edge     = 1'b1;
    initial begin
        forever begin
            @(posedge clk);
            s_edge = start;
            r_edge = rst;
        end
    end

    logic          exp_busy    = 1'b0;
    logic          pend_eofhs  = 1'b0;
    logic          prev_stall  = 1'b0;
    logic          lat_pending = 1'b0;
    beat_t         prev_beat;
    logic [AW-1:0] prev_addr;
    int            ncyc        = 0;
    int            hs_count    = 0;
    int            hs_first    = 0;
    int            hs_last     = 0;
    int            busy_cnt    = 0;

    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            ncyc++;
            check("done", done, !r_edge && pend_eofhs);
            if (r_edge) begin
                exp_busy    = 1'b0;
                lat_pending = 1'b0;
                exp_q.delete();
                check("rst_valid", pix.pix_valid, 0);
                check("rst_addr", read_addr, 0);
                check("rst_data", pix.pix_data, 0);
                check("rst_marks", {pix.pix_sof, pix.pix_eol, pix.pix_eof}, 0);
            end else if (pend_eofhs) begin
                exp_busy = 1'b0;
            end else if (s_edge && !exp_busy) begin
                exp_busy = 1'b1;
                check("lat_first_edge_valid", pix.pix_valid, 0);
                check("lat_start_addr", read_addr, 0);
                lat_pending = 1'b1;
            end else if (lat_pending) begin
                check("lat_second_edge_valid", pix.pix_valid, 1);
                lat_pending = 1'b0;
            end
            check("busy", busy, exp_busy);
            check("addr_range", read_addr < AW'(N), 1);
            if (busy) busy_cnt++;

            if (prev_stall && !r_edge) begin
                check("stall_valid", pix.pix_valid, 1);
                check("stall_data", pix.pix_data, prev_beat.data);
                check("stall_marks", {pix.pix_sof, pix.pix_eol, pix.pix_eof},
                      {prev_beat.sof, prev_beat.eol, prev_beat.eof});
                check("stall_addr", read_addr, prev_addr);
            end

            pend_eofhs = 1'b0;
            if (pix.pix_valid && pix.pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("pix_data", pix.pix_data, b.data);
                    check("pix_sof", pix.pix_sof, b.sof);
                    check("pix_eol", pix.pix_eol, b.eol);
                    check("pix_eof", pix.pix_eof, b.eof);
                end
                if (hs_count == 0) hs_first = ncyc;
                hs_last = ncyc;
                hs_count++;
                pend_eofhs = pix.pix_eof;
            end
            prev_stall = pix.pix_valid && !pix.pix_ready;
            prev_beat  = '{data: pix.pix_data, sof: pix.pix_sof, eol: pix.pix_eol, eof: pix.pix_eof};
            prev_addr  = read_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input bit sequential);
        for (int i = 0; i < N; i++) begin
            mem[i] = sequential ? DW'(i + 8) : DW'($urandom);
        end
    endtask

    task automatic start_frame();
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!done && n < limit);
        check("done_seen", done, 1);
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        fill_mem(1);
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", pix.pix_valid, 0);
        check("reset_addr", read_addr, 0);
        rst = 1'b0;
        tick();

        // Sequential contents, ready held high: eight back-to-back beats.
        ready_mode = 0;
        hs_count   = 0;
        busy_cnt   = 0;
        start_frame();
        wait_done(40);
        check("f1_beats", hs_count, N);
        check("f1_no_bubbles", hs_last - hs_first, N - 1);
        check("f1_busy_cycles", busy_cnt, N + 1);
        check("f1_queue_empty", exp_q.size(), 0);
        tick();

        // Ready pattern 1,0,0 repeating.
        ready_mode = 1;
        hs_count   = 0;
        start_frame();
        wait_done(100);
        check("toggle_beats", hs_count, N);
        check("toggle_queue_empty", exp_q.size(), 0);
        tick();

        // Random contents and random ready.
        ready_mode = 2;
        for (int f = 0; f < 4; f++) begin
            fill_mem(0);
            hs_count = 0;
            start_frame();
            wait_done(200);
            check("rand_beats", hs_count, N);
            check("rand_queue_empty", exp_q.size(), 0);
            tick();
        end

        // Start pulses during an active frame are ignored; restart one cycle after done.
        ready_mode = 0;
        fill_mem(0);
        hs_count = 0;
        start_frame();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40);
        check("ignore_beats", hs_count, N);
        tick();
        hs_count = 0;
        start_frame();
        check("restart_addr", read_addr, 0);
        wait_done(40);
        check("restart_beats", hs_count, N);
        tick();

        // Reset with the 4th beat stalled abandons the frame.
        fill_mem(0);
        hs_count = 0;
        start_frame();
        n = 0;
        while (hs_count < 3 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("midrst_reach_beat3", hs_count, 3);
        ready_mode = 3;
        tick();
        check("midrst_beat4_valid", pix.pix_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", pix.pix_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", read_addr, 0);
        check("midrst_done", done, 0);
        tick();
        check("midrst_no_done", done, 0);
        ready_mode = 0;
        tick();
        hs_count = 0;
        start_frame();
        wait_done(40);
        check("postrst_beats", hs_count, N);

        // Back-to-back: start raised during the done cycle.
        fill_mem(0);
        hs_count = 0;
        start_frame();
        wait_done(40);
        start_frame();
        wait_done(40);
        check("b2b_beats", hs_count, 2 * N);
        check("b2b_queue_empty", exp_q.size(), 0);
        tick();

        // 1x1 frame: a single beat carrying every marker.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pix1.pix_valid && n < 10);
        check("one_valid", pix1.pix_valid, 1);
        check("one_latency", n, 2);
        check("one_data", pix1.pix_data, 8'hA5);
        check("one_marks", {pix1.pix_sof, pix1.pix_eol, pix1.pix_eof}, 3'b111);
        check("one_busy", busy1, 1);
        check("one_addr", read_addr1, 0);
        @(negedge clk);
        check("one_done", done1, 1);
        check("one_valid_after", pix1.pix_valid, 0);
        check("one_busy_after", busy1, 0);
        @(negedge clk);
        check("one_done_pulse", done1, 0);

        tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
